ramb4_s2_arbiter: RTL
=====================

RAMB4_S2_ARBITER -- requirements
Module: ramb4_s2_arbiter

Interface
REQ-001 Parameter CLR_VALUE, default 2'b00, data word written to every location during a clear sweep.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 REQ_A, REQ_B  input  1 each  access request, held high until GNT seen.
REQ-005 ADDR_A, ADDR_B  input  11 each  word address, 2048 x 2-bit space.
REQ-006 WE_A, WE_B  input  1 each  1 = write, 0 = read.
REQ-007 DI_A, DI_B  input  2 each  write data.
REQ-008 GNT_A, GNT_B  output  1 each  one-cycle pulse: request accepted, inputs sampled.
REQ-009 ACK_A, ACK_B  output  1 each  one-cycle pulse: RDATA valid.
REQ-010 RDATA  output  2  read data (write: the written data, write-first).
REQ-011 CLR_START  input  1  pulse: request full-memory clear.
REQ-012 CLR_BUSY  output  1  high throughout the clear sweep.
REQ-013 CLR_DONE  output  1  one-cycle pulse after the last clear write.
REQ-014 RAM_EN, RAM_WE  output  1 each  to RAM EN/WE, registered.
REQ-015 RAM_ADDR  output  11  to RAM ADDR, registered.
REQ-016 RAM_DI  output  2  to RAM DI, registered.
REQ-017 RAM_RST  output  1  to RAM RST, constant 0.
REQ-018 RAM_DO  input  2  from RAM DO, valid one edge after the RAM_EN edge.

Function
REQ-019 FSM states IDLE, ACCESS, RESP, CLEAR; reset state IDLE.
REQ-020 IDLE, edge k: clear pending -> CLEAR; else any REQ -> ACCESS with winner sampled; else stay.
REQ-021 Arbitration round-robin: 1-bit pointer, both requesting -> pointer side wins; pointer moves to the loser after every grant.
REQ-022 Single requester wins regardless of pointer; pointer still moves to the other side.
REQ-023 Grant at edge k: GNT_x=1, RAM_EN=1, RAM_WE/RAM_ADDR/RAM_DI = winner's inputs, all during cycle k..k+1.
REQ-024 ACCESS, edge k+1: RAM_EN=0, RAM_WE=0, GNT_x=0, state -> RESP.
REQ-025 RESP, edge k+2: RDATA <= RAM_DO, ACK_x=1 for one cycle, state -> IDLE.
REQ-026 Access latency: GNT 1 edge after REQ sampled, ACK 3 edges after; max one access per 3 cycles.
REQ-027 RDATA holds last captured value until next ACK.
REQ-028 CLR_START sampled on any edge sets clear-pending flag; flag cleared on entry to CLEAR; repeated pulses while pending or CLEAR are merged/ignored.
REQ-029 Clear has priority over both REQs in IDLE; an in-progress ACCESS/RESP completes first.
REQ-030 CLEAR: 11-bit counter from 0; each cycle RAM_EN=1, RAM_WE=1, RAM_ADDR=count, RAM_DI=CLR_VALUE; 2048 consecutive writes.
REQ-031 After the write with address 2047: RAM_EN=0, CLR_BUSY=0, CLR_DONE=1 for one cycle, counter returns to 0, state -> IDLE.
REQ-032 CLR_BUSY rises at the edge entering CLEAR, falls with CLR_DONE.
REQ-033 REQs during CLEAR receive no GNT; arbitration resumes the edge after CLR_DONE with pointer unchanged.
REQ-034 GNT_A and GNT_B never both 1; ACK_A and ACK_B never both 1.

Reset
REQ-035 RST_N low forces immediately: state IDLE, pointer A, clear-pending 0, counter 0.
REQ-036 RST_N low forces all outputs 0: GNT_*, ACK_*, RDATA, CLR_BUSY, CLR_DONE, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI.
REQ-037 Reset mid-access or mid-clear abandons the operation; no ACK or CLR_DONE issued afterwards.
REQ-038 First arbitration edge after RST_N rises follows REQ-020.

Verification
REQ-039 Write A addr 0x005 data 2'b10, then read A 0x005 -> GNT at +1, ACK_A at +3, RDATA=2'b10 both times.
REQ-040 REQ_A and REQ_B held high from reset -> grants A,B,A,B..., each GNT 3 cycles apart, no double grant.
REQ-041 CLR_START with REQ_A held -> CLR_BUSY 2048 cycles, RAM_ADDR 0..2047 with WE=1, CLR_DONE once, then GNT_A.
REQ-042 CLR_START during ACCESS -> ACK of that access first, then CLEAR in next IDLE; read of 0x7FF afterwards returns CLR_VALUE.
REQ-043 RST_N low at clear count 1000 -> all outputs 0 at once, no CLR_DONE; after release, new CLR_START completes a full 2048-write sweep.

Source files
------------

// File: rtl/ramb4_s2_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ramb4_s2_arbiter_if
//  Description : Bundle of the two-port request/grant bus, the clear-sweep
//                control and the single-port RAM (2048 x 2-bit) connection.
//  Revision    : 1.0  initial release
// ============================================================================
interface ramb4_s2_arbiter_if;
  // requester A
  logic        req_a;
  logic [10:0] addr_a;
  logic        we_a;
  logic [1:0]  di_a;
  // requester B
  logic        req_b;
  logic [10:0] addr_b;
  logic        we_b;
  logic [1:0]  di_b;
  // responses
  logic        gnt_a;
  logic        gnt_b;
  logic        ack_a;
  logic        ack_b;
  logic [1:0]  rdata;
  // clear sweep
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  // RAM side
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [1:0]  ram_di;
  logic        ram_rst;
  logic [1:0]  ram_do;

  // Arbiter side of the bundle
  modport slave (
    input  req_a, addr_a, we_a, di_a,
    input  req_b, addr_b, we_b, di_b,
    input  clr_start, ram_do,
    output gnt_a, gnt_b, ack_a, ack_b, rdata,
    output clr_busy, clr_done,
    output ram_en, ram_we, ram_addr, ram_di, ram_rst
  );

  // Environment side: requesters, clear controller and the RAM itself
  modport master (
    output req_a, addr_a, we_a, di_a,
    output req_b, addr_b, we_b, di_b,
    output clr_start, ram_do,
    input  gnt_a, gnt_b, ack_a, ack_b, rdata,
    input  clr_busy, clr_done,
    input  ram_en, ram_we, ram_addr, ram_di, ram_rst
  );
endinterface
`default_nettype wire

// File: rtl/ramb4_s2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ramb4_s2_arbiter
//  Description : Round-robin two-port arbiter in front of a single-port
//                2048 x 2-bit RAM, with a full-memory clear sweep that takes
//                priority over requests whenever the arbiter is idle.
//  Revision    : 1.0  initial release
// ============================================================================
module ramb4_s2_arbiter #(
  parameter logic [1:0] CLR_VALUE = 2'b00
) (
  input  logic              clk,
  input  logic              rst_n,
  ramb4_s2_arbiter_if.slave bus
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_ACCESS    = 2'd1;
  localparam logic [1:0]  S_RESP      = 2'd2;
  localparam logic [1:0]  S_CLEAR     = 2'd3;
  localparam logic [10:0] C_LAST_ADDR = 11'h7FF;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;          // 0 = A has priority, 1 = B
  logic        pend_q, pend_d;        // clear requested, not yet started
  logic        win_q, win_d;          // side granted for the access in flight
  logic [10:0] cnt_q, cnt_d;          // clear sweep address
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic [1:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [10:0] ram_addr_q, ram_addr_d;
  logic [1:0]  ram_di_q, ram_di_d;

  logic        w_clr_req;
  logic        w_any_req;
  logic        w_win;
  logic        w_last;

  // A pulse arriving on the same edge the arbiter is idle counts as pending.
  assign w_clr_req = pend_q | bus.clr_start;
  assign w_any_req = bus.req_a | bus.req_b;
  assign w_win     = (bus.req_a & bus.req_b) ? ptr_q : bus.req_b;
  assign w_last    = (cnt_q == C_LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision: clear beats requests, accesses run to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_clr_req) begin
          state_d = S_CLEAR;
        end else if (w_any_req) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      S_CLEAR: begin
        if (w_last) begin
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping registers
  always_comb begin
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    rdata_d    = rdata_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    // pulses seen while sweeping are dropped; otherwise they are remembered
    pend_d     = pend_q | (bus.clr_start & (state_q != S_CLEAR));
    case (state_q)
      S_IDLE: begin
        if (w_clr_req) begin
          pend_d     = 1'b0;
          cnt_d      = 11'd0;
          busy_d     = 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = 11'd0;
          ram_di_d   = CLR_VALUE;
        end else if (w_any_req) begin
          win_d      = w_win;
          ptr_d      = ~w_win;
          gnt_a_d    = ~w_win;
          gnt_b_d    = w_win;
          ram_en_d   = 1'b1;
          ram_we_d   = w_win ? bus.we_b   : bus.we_a;
          ram_addr_d = w_win ? bus.addr_b : bus.addr_a;
          ram_di_d   = w_win ? bus.di_b   : bus.di_a;
        end
      end
      S_RESP: begin
        rdata_d = bus.ram_do;
        ack_a_d = ~win_q;
        ack_b_d = win_q;
      end
      S_CLEAR: begin
        if (w_last) begin
          cnt_d  = 11'd0;
          done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 11'd1;
          busy_d     = 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = cnt_q + 11'd1;
          ram_di_d   = CLR_VALUE;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      pend_q     <= 1'b0;
      win_q      <= 1'b0;
      cnt_q      <= 11'd0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      rdata_q    <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 11'd0;
      ram_di_q   <= 2'b00;
    end else begin
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
    end
  end

  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.rdata    = rdata_q;
  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_di   = ram_di_q;
  assign bus.ram_rst  = 1'b0;

endmodule
`default_nettype wire
